// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: control-state encoding and counter sizing
// common to the radix-4 multiplier and the 2-bit-per-cycle divider.
package arith_pkg;

  typedef enum logic {
    RESTING     = 1'b0,
    MULTIPLYING = 1'b1
  } state_e;

  // Bits needed to hold an iteration count of width/2 down to 1.
  function automatic int count_width(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/multiplier2b_if.sv
// Operand/result handshake bundle for multiplier2b (same signalling as the divider).
interface multiplier2b_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   multiplicand_in;
  logic [WIDTH-1:0]   multiplier_in;
  logic               data_valid_in;
  logic [2*WIDTH-1:0] product_out;
  logic               data_valid_out;
  logic               busy_out;

  modport slave (
    input  multiplicand_in, multiplier_in, data_valid_in,
    output product_out, data_valid_out, busy_out
  );

  modport master (
    output multiplicand_in, multiplier_in, data_valid_in,
    input  product_out, data_valid_out, busy_out
  );
endinterface

// File: rtl/mult_pp2.sv
// Radix-4 partial-product cell: selects A and 2A from two multiplier bits.
// Kept standalone so a Booth radix-4 cell can replace it later.
module mult_pp2 #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_a,
  input  logic [1:0]         i_b_bits,
  output logic [2*WIDTH-1:0] o_pp
);
  logic [2*WIDTH-1:0] w_pp_lo;
  logic [2*WIDTH-1:0] w_pp_hi;

  assign w_pp_lo = i_b_bits[0] ? i_a : '0;
  assign w_pp_hi = i_b_bits[1] ? (i_a << 1) : '0;
  assign o_pp    = w_pp_lo + w_pp_hi;
endmodule

// File: rtl/multiplier2b.sv
// Iterative unsigned shift-add multiplier retiring two multiplier bits per cycle.
// Define MULTIPLIER2B_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier2b
  import arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  multiplier2b_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = count_width(WIDTH);

  if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("multiplier2b: WIDTH must be even and >= 4");
  end

  state_e            r_state;
  state_e            w_state_next;
  logic [PW-1:0]     r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PW-1:0]     r_acc;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_product;
  logic              r_valid;
  logic              r_busy;

  logic [PW-1:0]     w_pp;
  logic [PW-1:0]     w_acc_next;
  logic [WIDTH-1:0]  w_b_shift;
  logic              w_accept;
  logic              w_done;

  mult_pp2 #(.WIDTH(WIDTH)) u_pp2 (
    .i_a      (r_a),
    .i_b_bits (r_b[1:0]),
    .o_pp     (w_pp)
  );

  // A is zero-extended to PW, so the sum cannot overflow the accumulator.
  assign w_acc_next = r_acc + w_pp;
  assign w_b_shift  = r_b >> 2;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      RESTING: begin
        if (bus.data_valid_in) begin
          w_accept     = 1'b1;
          w_state_next = MULTIPLYING;
        end
      end
      MULTIPLYING: begin
`ifdef MULTIPLIER2B_EARLY_EXIT_EN
        w_done = (r_count == CW'(1)) || (w_b_shift == '0);
`else
        w_done = (r_count == CW'(1));
`endif
        if (w_done) begin
          w_state_next = RESTING;
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= RESTING;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_done;
      if (w_accept) begin
        r_a     <= {{WIDTH{1'b0}}, bus.multiplicand_in};
        r_b     <= bus.multiplier_in;
        r_acc   <= '0;
        r_count <= CW'(WIDTH / 2);
        r_busy  <= 1'b1;
      end else if (r_state == MULTIPLYING) begin
        r_a     <= r_a << 2;
        r_b     <= w_b_shift;
        r_acc   <= w_acc_next;
        r_count <= r_count - CW'(1);
        // The result register only moves at completion; partial sums stay internal.
        if (w_done) begin
          r_product <= w_acc_next;
          r_busy    <= 1'b0;
        end
      end
    end
  end

  assign bus.product_out    = r_product;
  assign bus.data_valid_out = r_valid;
  assign bus.busy_out       = r_busy;
endmodule

// File: tb/tb_multiplier2b.sv
// Directed bench for multiplier2b (WIDTH=8) plus a short WIDTH=32 sweep against a
// behavioural multiply; follows MULTIPLIER2B_EARLY_EXIT_EN for expected latencies.
module tb_multiplier2b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier2b_if #(.WIDTH(8))  bus8  ();
  multiplier2b_if #(.WIDTH(32)) bus32 ();

  multiplier2b #(.WIDTH(8)) dut8 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus8)
  );

  multiplier2b #(.WIDTH(32)) dut32 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Expected latency for the 8-bit directed vectors: (fixed, early-exit).
  function automatic int lat8(input int fixed_lat, input int early_lat);
`ifdef MULTIPLIER2B_EARLY_EXIT_EN
    return early_lat;
`else
    return fixed_lat;
`endif
  endfunction

  function automatic int lat32(input logic [31:0] b);
`ifdef MULTIPLIER2B_EARLY_EXIT_EN
    int msb = 0;
    if (b == 0) return 1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return (msb + 2) / 2;
`else
    return 16;
`endif
  endfunction

  // Present operands for one cycle; returns just after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    bus8.multiplicand_in = a;
    bus8.multiplier_in   = b;
    bus8.data_valid_in   = 1'b1;
    @(posedge clk); #1;
    bus8.data_valid_in   = 1'b0;
  endtask

  task automatic wait_done8(input string tag, input logic [15:0] exp_p, input int exp_lat,
                            input bit junk, output int pulse_cyc);
    int lat = -1;
    int busy_bad = 0;
    check({tag, "_busy_accept"}, 64'(bus8.busy_out), 64'(1));
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus8.data_valid_in = 1'b0;
      if (bus8.data_valid_out === 1'b1) begin
        lat = i;
        break;
      end
      if (bus8.busy_out !== 1'b1) busy_bad++;
      if (junk && i == 1) begin
        bus8.multiplicand_in = 8'hA5;
        bus8.multiplier_in   = 8'h5A;
        bus8.data_valid_in   = 1'b1;
      end
    end
    pulse_cyc = cyc;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_product"}, 64'(bus8.product_out), 64'(exp_p));
    check({tag, "_busy_gap"}, 64'(busy_bad), 64'(0));
    check({tag, "_busy_done"}, 64'(bus8.busy_out), 64'(0));
  endtask

  initial begin
    int p0, p1;
    bus8.multiplicand_in  = '0;
    bus8.multiplier_in    = '0;
    bus8.data_valid_in    = 1'b0;
    bus32.multiplicand_in = '0;
    bus32.multiplier_in   = '0;
    bus32.data_valid_in   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_product", 64'(bus8.product_out), 64'(0));
    check("rst_valid", 64'(bus8.data_valid_out), 64'(0));
    check("rst_busy", 64'(bus8.busy_out), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic product with an ignored strobe while busy, then pulse width and hold.
    issue8(8'd13, 8'd11);
    wait_done8("m13x11", 16'd143, lat8(4, 2), 1'b1, p0);
    @(posedge clk); #1;
    check("pulse_width", 64'(bus8.data_valid_out), 64'(0));
    check("product_hold", 64'(bus8.product_out), 64'(143));

    issue8(8'd255, 8'd255);
    wait_done8("m255x255", 16'd65025, lat8(4, 4), 1'b0, p0);
    issue8(8'd0, 8'd200);
    wait_done8("m0x200", 16'd0, lat8(4, 4), 1'b0, p0);
    issue8(8'd1, 8'd0);
    wait_done8("m1x0", 16'd0, lat8(4, 1), 1'b0, p0);

    // Back-to-back: next strobe lands in the data_valid_out cycle.
    issue8(8'd7, 8'd9);
    wait_done8("m7x9", 16'd63, lat8(4, 2), 1'b1, p0);
    issue8(8'd100, 8'd3);
    wait_done8("m100x3", 16'd300, lat8(4, 1), 1'b0, p1);
    check("b2b_spacing", 64'(p1 - p0), 64'(lat8(4, 1) + 1));

    // Reset mid-operation aborts without a completion pulse.
    issue8(8'd50, 8'd50);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_product", 64'(bus8.product_out), 64'(0));
    check("abort_busy", 64'(bus8.busy_out), 64'(0));
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (bus8.data_valid_out !== 1'b0) seen++;
        if (rst_n == 1'b0 && cyc % 2 == 0) rst_n = 1'b1;
      end
      rst_n = 1'b1;
      check("abort_no_valid", 64'(seen), 64'(0));
    end
    check("abort_product_after", 64'(bus8.product_out), 64'(0));
    issue8(8'd6, 8'd7);
    wait_done8("m6x7", 16'd42, lat8(4, 2), 1'b0, p0);

    // Wide sweep against a behavioural multiply.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      logic [63:0] exp_p;
      int lat = -1;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (n == 0) b = 32'd0;
      if (n == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      exp_p = 64'(a) * 64'(b);
      bus32.multiplicand_in = a;
      bus32.multiplier_in   = b;
      bus32.data_valid_in   = 1'b1;
      @(posedge clk); #1;
      bus32.data_valid_in   = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (bus32.data_valid_out === 1'b1) begin
          lat = i;
          break;
        end
      end
      check($sformatf("w32_lat_%0d", n), 64'(lat), 64'(lat32(b)));
      check($sformatf("w32_prod_%0d", n), bus32.product_out, exp_p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
